// File: rtl/systolic_matmul_engine.sv
// rtl/systolic_matmul_engine.sv - output-stationary NxN systolic matrix-multiply core
module systolic_matmul_engine #(
  parameter int ARR_SIZE = 4,
  parameter int DATA_W   = 16,
  parameter int ACC_W    = 32,
  parameter int K_W      = 16,
  parameter int SATURATE = 0
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         start,
  input  logic [K_W-1:0]               k_len,
  input  logic [ARR_SIZE*DATA_W-1:0]   a_col,
  input  logic [ARR_SIZE*DATA_W-1:0]   b_row,
  input  logic                         in_valid,
  output logic                         in_ready,
  output logic [ARR_SIZE*ACC_W-1:0]    out_data,
  output logic [$clog2(ARR_SIZE)-1:0]  out_row,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic                         busy,
  output logic                         done
);

  localparam int N  = ARR_SIZE;
  localparam int RW = $clog2(N);
  localparam int FW = $clog2(2 * N);
  localparam logic [FW-1:0] FLUSH_LAST = FW'(2 * N - 2);
  localparam logic [RW-1:0] ROW_LAST   = RW'(N - 1);
  localparam logic signed [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FEED  = 2'd1,
    S_FLUSH = 2'd2,
    S_DRAIN = 2'd3
  } state_t;

  state_t r_state;
  state_t w_state_nxt;

  logic                 w_job_start;
  logic                 w_adv;
  logic                 w_feed_last;
  logic [K_W-1:0]       r_k_len;
  logic [K_W-1:0]       r_beat_cnt;
  logic [FW-1:0]        r_flush_cnt;
  logic [N*ACC_W-1:0]   r_out_data;
  logic [RW-1:0]        r_out_row;
  logic [RW-1:0]        w_row_nxt;
  logic                 r_out_valid;
  logic                 r_done;

  // operands injected at the array edge (zeros during flush), their skewed
  // versions, the per-PE operand inputs and the forwarding registers between PEs
  logic signed [DATA_W-1:0] w_inj_a   [N];
  logic signed [DATA_W-1:0] w_inj_b   [N];
  logic signed [DATA_W-1:0] w_sk_a    [N];
  logic signed [DATA_W-1:0] w_sk_b    [N];
  logic signed [DATA_W-1:0] w_pe_a    [N][N];
  logic signed [DATA_W-1:0] w_pe_b    [N][N];
  logic signed [DATA_W-1:0] r_fwd_a   [N][N-1];
  logic signed [DATA_W-1:0] r_fwd_b   [N-1][N];
  logic signed [ACC_W-1:0]  r_acc     [N][N];
  logic signed [ACC_W-1:0]  w_acc_nxt [N][N];

  assign w_job_start = (r_state == S_IDLE) && start && (k_len != '0);
  assign w_feed_last = in_valid && (r_beat_cnt == (r_k_len - K_W'(1)));
  assign w_row_nxt   = r_out_row + RW'(1);

  // state register
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // next-state and state-decoded controls; in_ready depends on state only
  always_comb begin
    w_state_nxt = r_state;
    in_ready    = 1'b0;
    busy        = 1'b1;
    w_adv       = 1'b0;
    case (r_state)
      S_IDLE: begin
        busy = 1'b0;
        if (w_job_start) w_state_nxt = S_FEED;
      end
      S_FEED: begin
        in_ready = 1'b1;
        w_adv    = in_valid;
        if (w_feed_last) w_state_nxt = S_FLUSH;
      end
      S_FLUSH: begin
        w_adv = 1'b1;
        if (r_flush_cnt == FLUSH_LAST) w_state_nxt = S_DRAIN;
      end
      S_DRAIN: begin
        if (r_done) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // job length latch, accepted-beat counter and flush cycle counter
  always_ff @(posedge clk) begin
    if (rst) begin
      r_k_len     <= '0;
      r_beat_cnt  <= '0;
      r_flush_cnt <= '0;
    end else if (w_job_start) begin
      r_k_len     <= k_len;
      r_beat_cnt  <= '0;
      r_flush_cnt <= '0;
    end else if ((r_state == S_FEED) && in_valid) begin
      r_beat_cnt <= r_beat_cnt + K_W'(1);
    end else if (r_state == S_FLUSH) begin
      r_flush_cnt <= r_flush_cnt + FW'(1);
    end
  end

  genvar gi, gj;
  generate
    for (gi = 0; gi < N; gi++) begin : g_inj
      assign w_inj_a[gi] = (r_state == S_FEED) ? $signed(a_col[gi*DATA_W +: DATA_W]) : '0;
      assign w_inj_b[gi] = (r_state == S_FEED) ? $signed(b_row[gi*DATA_W +: DATA_W]) : '0;
    end

    assign w_sk_a[0] = w_inj_a[0];
    assign w_sk_b[0] = w_inj_b[0];

    for (gi = 1; gi < N; gi++) begin : g_skew
      logic signed [DATA_W-1:0] r_da [gi];
      logic signed [DATA_W-1:0] r_db [gi];

      // lane gi is delayed by gi advances so operands meet on the diagonal wavefront
      always_ff @(posedge clk) begin
        if (rst || w_job_start) begin
          for (int s = 0; s < gi; s++) begin
            r_da[s] <= '0;
            r_db[s] <= '0;
          end
        end else if (w_adv) begin
          r_da[0] <= w_inj_a[gi];
          r_db[0] <= w_inj_b[gi];
          for (int s = 1; s < gi; s++) begin
            r_da[s] <= r_da[s-1];
            r_db[s] <= r_db[s-1];
          end
        end
      end

      assign w_sk_a[gi] = r_da[gi-1];
      assign w_sk_b[gi] = r_db[gi-1];
    end

    for (gi = 0; gi < N; gi++) begin : g_row
      for (gj = 0; gj < N; gj++) begin : g_col
        logic signed [2*DATA_W-1:0] w_prod;

        if (gj == 0) begin : g_a_edge
          assign w_pe_a[gi][gj] = w_sk_a[gi];
        end else begin : g_a_fwd
          assign w_pe_a[gi][gj] = r_fwd_a[gi][gj-1];
        end

        if (gi == 0) begin : g_b_edge
          assign w_pe_b[gi][gj] = w_sk_b[gj];
        end else begin : g_b_fwd
          assign w_pe_b[gi][gj] = r_fwd_b[gi-1][gj];
        end

        assign w_prod = (2*DATA_W)'(w_pe_a[gi][gj]) * (2*DATA_W)'(w_pe_b[gi][gj]);

        if (SATURATE != 0) begin : g_sat
          // one guard bit detects overflow; clamp toward the sign of the true sum
          logic signed [ACC_W:0] w_sum;
          assign w_sum = (ACC_W+1)'(r_acc[gi][gj]) + (ACC_W+1)'(w_prod);
          assign w_acc_nxt[gi][gj] = (w_sum[ACC_W] != w_sum[ACC_W-1]) ?
                                     (w_sum[ACC_W] ? ACC_MIN : ACC_MAX) :
                                     w_sum[ACC_W-1:0];
        end else begin : g_wrap
          assign w_acc_nxt[gi][gj] = r_acc[gi][gj] + ACC_W'(w_prod);
        end
      end
    end
  endgenerate

  // PE accumulators and operand forwarding; everything moves only on an advance
  always_ff @(posedge clk) begin
    if (rst || w_job_start) begin
      for (int i = 0; i < N; i++) begin
        for (int j = 0; j < N; j++) begin
          r_acc[i][j] <= '0;
        end
        for (int j = 0; j < N - 1; j++) begin
          r_fwd_a[i][j] <= '0;
        end
      end
      for (int i = 0; i < N - 1; i++) begin
        for (int j = 0; j < N; j++) begin
          r_fwd_b[i][j] <= '0;
        end
      end
    end else if (w_adv) begin
      for (int i = 0; i < N; i++) begin
        for (int j = 0; j < N; j++) begin
          r_acc[i][j] <= w_acc_nxt[i][j];
        end
        for (int j = 0; j < N - 1; j++) begin
          r_fwd_a[i][j] <= w_pe_a[i][j];
        end
      end
      for (int i = 0; i < N - 1; i++) begin
        for (int j = 0; j < N; j++) begin
          r_fwd_b[i][j] <= w_pe_b[i][j];
        end
      end
    end
  end

  // result drain: one accumulator row at a time, held while the consumer stalls;
  // done pulses in the cycle after the last row is taken, still in DRAIN
  always_ff @(posedge clk) begin
    if (rst) begin
      r_out_valid <= 1'b0;
      r_out_row   <= '0;
      r_out_data  <= '0;
      r_done      <= 1'b0;
    end else if (r_state == S_DRAIN) begin
      r_done <= 1'b0;
      if (!r_out_valid && !r_done) begin
        r_out_valid <= 1'b1;
        r_out_row   <= '0;
        for (int j = 0; j < N; j++) begin
          r_out_data[j*ACC_W +: ACC_W] <= r_acc[0][j];
        end
      end else if (r_out_valid && out_ready) begin
        if (r_out_row == ROW_LAST) begin
          r_out_valid <= 1'b0;
          r_done      <= 1'b1;
        end else begin
          r_out_row <= w_row_nxt;
          for (int j = 0; j < N; j++) begin
            r_out_data[j*ACC_W +: ACC_W] <= r_acc[w_row_nxt][j];
          end
        end
      end
    end else begin
      r_out_valid <= 1'b0;
      r_done      <= 1'b0;
    end
  end

  assign out_data  = r_out_data;
  assign out_row   = r_out_row;
  assign out_valid = r_out_valid;
  assign done      = r_done;

endmodule

// File: tb/tb_systolic_matmul_engine.sv
// tb/tb_systolic_matmul_engine.sv - scoreboard bench for the systolic matmul engine
module tb_systolic_matmul_engine;

  localparam int N    = 4;
  localparam int DW   = 16;
  localparam int AW   = 32;
  localparam int KW   = 16;
  localparam int CW   = N * AW;
  localparam int KMAX = 8;

  logic            clk = 1'b0;
  logic            rst;
  logic            start;
  logic [KW-1:0]   k_len;
  logic [N*DW-1:0] a_col;
  logic [N*DW-1:0] b_row;
  logic            in_valid;
  logic            out_ready;

  logic            in_ready0, out_valid0, busy0, done0;
  logic [CW-1:0]   out_data0;
  logic [1:0]      out_row0;
  logic            in_ready1, out_valid1, busy1, done1;
  logic [CW-1:0]   out_data1;
  logic [1:0]      out_row1;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  int n_done  = 0;
  int exp_done = 0;
  int t_first = 0;
  int t_last  = 0;
  int t_row3  = 0;
  int t_done  = 0;
  logic prev_valid = 1'b0;

  logic signed [DW-1:0] ma [N][KMAX];
  logic signed [DW-1:0] mb [KMAX][N];
  logic [CW-1:0] model_rows [N];

  logic [CW-1:0] q0_data [$];
  int            q0_row  [$];
  logic [CW-1:0] q1_data [$];
  int            q1_row  [$];

  systolic_matmul_engine #(.ARR_SIZE(N), .DATA_W(DW), .ACC_W(AW), .K_W(KW), .SATURATE(0)) dut (
    .clk(clk), .rst(rst), .start(start), .k_len(k_len), .a_col(a_col), .b_row(b_row),
    .in_valid(in_valid), .in_ready(in_ready0), .out_data(out_data0), .out_row(out_row0),
    .out_valid(out_valid0), .out_ready(out_ready), .busy(busy0), .done(done0)
  );

  systolic_matmul_engine #(.ARR_SIZE(N), .DATA_W(DW), .ACC_W(AW), .K_W(KW), .SATURATE(1)) dut_sat (
    .clk(clk), .rst(rst), .start(start), .k_len(k_len), .a_col(a_col), .b_row(b_row),
    .in_valid(in_valid), .in_ready(in_ready1), .out_data(out_data1), .out_row(out_row1),
    .out_valid(out_valid1), .out_ready(out_ready), .busy(busy1), .done(done1)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [CW-1:0] act, input logic [CW-1:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // monitor: pops the scoreboard on every accepted row of either instance
  always @(negedge clk) begin
    if (!rst) begin
      if (out_valid0 && out_ready) begin
        if (q0_data.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL dut0_unexpected_row: got row %0d expected none", out_row0);
        end else begin
          check("dut0_row", CW'(out_row0), CW'(q0_row.pop_front()));
          check("dut0_data", out_data0, q0_data.pop_front());
          if (out_row0 == 2'd3) t_row3 = cyc;
        end
      end
      if (out_valid1 && out_ready) begin
        if (q1_data.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL dut1_unexpected_row: got row %0d expected none", out_row1);
        end else begin
          check("dut1_row", CW'(out_row1), CW'(q1_row.pop_front()));
          check("dut1_data", out_data1, q1_data.pop_front());
        end
      end
      if (out_valid0 && !prev_valid) t_first = cyc;
      prev_valid = out_valid0;
      if (done0) begin
        n_done++;
        t_done = cyc;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_job(input int k);
    start = 1'b1;
    k_len = KW'(k);
    tick();
    start = 1'b0;
  endtask

  task automatic set_beat(input int t);
    for (int i = 0; i < N; i++) begin
      a_col[i*DW +: DW] = ma[i][t % KMAX];
      b_row[i*DW +: DW] = mb[t % KMAX][i];
    end
  endtask

  task automatic feed(input int k, input logic [31:0] vpat, output int nacc);
    int   idx = 0;
    logic acc;
    nacc = 0;
    while (nacc < k && idx < 100) begin
      in_valid = vpat[idx % 32];
      set_beat(nacc);
      @(negedge clk);
      acc = in_valid && in_ready0;
      tick();
      if (acc) begin
        nacc++;
        if (nacc == k) t_last = cyc;
      end
      idx++;
    end
    in_valid = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    int g = 0;
    while (busy0 && g < 200) begin
      tick();
      g++;
    end
    check(name, CW'(busy0), '0);
  endtask

  task automatic push_model(input int k);
    for (int r = 0; r < N; r++) begin
      logic [CW-1:0] row;
      row = '0;
      for (int j = 0; j < N; j++) begin
        longint s;
        s = 0;
        for (int t = 0; t < k; t++) s += longint'(ma[r][t]) * longint'(mb[t][j]);
        row[j*AW +: AW] = s[AW-1:0];
      end
      model_rows[r] = row;
      q0_data.push_back(row);
      q0_row.push_back(r);
      q1_data.push_back(row);
      q1_row.push_back(r);
    end
    exp_done++;
  endtask

  task automatic push_const(input logic [AW-1:0] v0, input logic [AW-1:0] v1);
    for (int r = 0; r < N; r++) begin
      q0_data.push_back({N{v0}});
      q0_row.push_back(r);
      q1_data.push_back({N{v1}});
      q1_row.push_back(r);
    end
    exp_done++;
  endtask

  task automatic fill(input logic signed [DW-1:0] av, input logic signed [DW-1:0] bv);
    for (int i = 0; i < N; i++) begin
      for (int t = 0; t < KMAX; t++) begin
        ma[i][t] = av;
        mb[t][i] = bv;
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int nacc;
    int bad;
    int g;
    int cnt;
    logic [CW-1:0] row;

    rst = 1'b1; start = 1'b0; k_len = '0; a_col = '0; b_row = '0;
    in_valid = 1'b0; out_ready = 1'b1;
    fill(16'sd0, 16'sd0);
    tick();
    tick();
    check("reset_data", out_data0 | out_data1, '0);
    check("reset_ctrl", CW'({in_ready0, out_valid0, busy0, done0, out_row0,
                             in_ready1, out_valid1, busy1, done1, out_row1}), '0);
    rst = 1'b0;
    tick();
    check("idle_in_ready", CW'(in_ready0), '0);

    // identity A: the result rows are the rows of B, B[k][j] = 4k+j
    for (int i = 0; i < N; i++) begin
      for (int t = 0; t < KMAX; t++) begin
        ma[i][t] = (i == t) ? 16'sd1 : 16'sd0;
        mb[t][i] = DW'(t * 4 + i);
      end
    end
    for (int r = 0; r < N; r++) begin
      row = '0;
      for (int j = 0; j < N; j++) row[j*AW +: AW] = AW'(r * 4 + j);
      q0_data.push_back(row); q0_row.push_back(r);
      q1_data.push_back(row); q1_row.push_back(r);
    end
    exp_done++;
    start_job(4);
    feed(4, 32'hFFFF_FFFF, nacc);
    check("t1_beats", CW'(nacc), CW'(4));
    wait_idle("t1_idle");
    check("t1_first_valid_latency", CW'(t_first - t_last), CW'(2 * N));
    check("t1_done_after_row3", CW'(t_done - t_row3), CW'(1));

    // signed operands with bubbles on in_valid
    fill(16'sd0, 16'sd0);
    ma[0][0] = 3;  ma[0][1] = -2; ma[0][2] = 5;
    ma[1][0] = -7; ma[1][1] = 1;  ma[1][2] = 0;
    ma[2][0] = 2;  ma[2][1] = 2;  ma[2][2] = -4;
    ma[3][0] = -1; ma[3][1] = 6;  ma[3][2] = 3;
    mb[0][0] = 1;  mb[0][1] = -3; mb[0][2] = 2;  mb[0][3] = 4;
    mb[1][0] = -5; mb[1][1] = 0;  mb[1][2] = 7;  mb[1][3] = -2;
    mb[2][0] = 6;  mb[2][1] = -1; mb[2][2] = -8; mb[2][3] = 3;
    push_model(3);
    start_job(3);
    feed(3, 32'b0110_1001_1010_0110_0101_1011_0010_1101, nacc);
    check("t2_beats", CW'(nacc), CW'(3));
    in_valid = 1'b1;
    bad = 0;
    g = 0;
    while (busy0 && g < 200) begin
      if (in_ready0) bad++;
      tick();
      g++;
    end
    in_valid = 1'b0;
    check("t2_in_ready_outside_feed", CW'(bad), '0);
    check("t2_idle", CW'(busy0), '0);

    // consumer stall on row 1
    for (int i = 0; i < N; i++) begin
      for (int t = 0; t < KMAX; t++) begin
        ma[i][t] = DW'(i + t + 1);
        mb[t][i] = DW'(i - t);
      end
    end
    push_model(2);
    out_ready = 1'b0;
    start_job(2);
    feed(2, 32'hFFFF_FFFF, nacc);
    g = 0;
    while (!out_valid0 && g < 100) begin
      tick();
      g++;
    end
    check("t3_row0_valid", CW'(out_valid0), CW'(1));
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    for (int s = 0; s < 5; s++) begin
      check("t3_hold_row", CW'({out_valid0, out_row0}), CW'(3'b101));
      check("t3_hold_data", out_data0, model_rows[1]);
      tick();
    end
    out_ready = 1'b1;
    wait_idle("t3_idle");

    // largest positive operands: wrap versus clamp
    fill(16'sh7FFF, 16'sh7FFF);
    push_const(32'hFFFC_0004, 32'h7FFF_FFFF);
    start_job(4);
    feed(4, 32'hFFFF_FFFF, nacc);
    wait_idle("t4_idle");

    // reset in the middle of a feed, then a fresh small job
    fill(16'sd300, -16'sd77);
    start_job(4);
    feed(2, 32'hFFFF_FFFF, nacc);
    rst = 1'b1;
    in_valid = 1'b1;
    tick();
    check("t5_reset_data", out_data0 | out_data1, '0);
    check("t5_reset_ctrl", CW'({in_ready0, out_valid0, busy0, done0, out_row0,
                                in_ready1, out_valid1, busy1, done1, out_row1}), '0);
    rst = 1'b0;
    in_valid = 1'b0;
    tick();
    fill(16'sd1, 16'sd2);
    push_const(32'd2, 32'd2);
    start_job(1);
    feed(1, 32'hFFFF_FFFF, nacc);
    wait_idle("t5_idle");

    // starts that must be ignored
    cnt = n_done;
    start_job(0);
    check("t6_klen0_busy", CW'(busy0), '0);
    for (int s = 0; s < 4; s++) tick();
    check("t6_klen0_no_done", CW'(n_done), CW'(cnt));

    for (int i = 0; i < N; i++) begin
      for (int t = 0; t < KMAX; t++) begin
        ma[i][t] = DW'(2 * i - t);
        mb[t][i] = DW'(t + 3 - i);
      end
    end
    push_model(2);
    start_job(2);
    start = 1'b1;
    k_len = KW'(7);
    tick();
    start = 1'b0;
    feed(2, 32'hFFFF_FFFF, nacc);
    check("t6_feed_restart_ignored", CW'({busy0, in_ready0}), CW'(2'b10));
    out_ready = 1'b0;
    g = 0;
    while (!out_valid0 && g < 100) begin
      tick();
      g++;
    end
    start = 1'b1;
    k_len = KW'(3);
    tick();
    start = 1'b0;
    check("t6_drain_start_ignored", CW'({busy0, out_valid0, out_row0}), CW'(4'b1100));
    out_ready = 1'b1;
    g = 0;
    while (!done0 && g < 100) begin
      tick();
      g++;
    end
    check("t6_done_seen", CW'(done0), CW'(1));
    start = 1'b1;
    k_len = KW'(1);
    tick();
    start = 1'b0;
    check("t6_start_on_done_ignored", CW'(busy0), '0);
    tick();
    check("t6_still_idle", CW'({busy0, in_ready0}), '0);

    for (int s = 0; s < 3; s++) tick();
    check("done_count", CW'(n_done), CW'(exp_done));
    check("scoreboard_empty", CW'(q0_data.size() + q1_data.size()), '0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
